// File: rtl/pic_rw_sequencer_pkg.sv
// Shared types and constants for the 8259 bus-interface sequencer.
// Optional readback path is enabled with the PIC_READBACK_EN macro.
package pic_pkg;

  localparam int PIC_DATA_W = 8;

  typedef enum logic [2:0] {
    UNINIT,
    WAIT_ICW2,
    WAIT_ICW3,
    WAIT_ICW4,
    READY
  } state_t;

  localparam int ICW1_B = 0;
  localparam int ICW2_B = 1;
  localparam int ICW3_B = 2;
  localparam int ICW4_B = 3;

  localparam int OCW1_B = 0;
  localparam int OCW2_B = 1;
  localparam int OCW3_B = 2;

  localparam int D0_B = 0;
  localparam int D1_B = 1;
  localparam int D3_B = 3;
  localparam int D4_B = 4;

  // ICW3 is only expected in cascade mode, ICW4 only when ICW1 asked for it
  function automatic state_t next_after_icw2(input logic sngl, input logic ic4);
    if (!sngl)
      return WAIT_ICW3;
    else if (ic4)
      return WAIT_ICW4;
    else
      return READY;
  endfunction

  function automatic state_t next_after_icw3(input logic ic4);
    return ic4 ? WAIT_ICW4 : READY;
  endfunction

endpackage

// File: rtl/pic_rw_sequencer_if.sv
// CPU-facing bus bundle of the sequencer; slave = sequencer, master = CPU side.
// Readback signals exist only when PIC_READBACK_EN is defined.
interface pic_rw_sequencer_if;
  import pic_pkg::*;

  logic                  i_cs_n;
  logic                  i_wr_n;
  logic                  i_rd_n;
  logic                  i_a0;
  logic [PIC_DATA_W-1:0] i_din;
  logic [3:0]            o_icw_stb;
  logic [2:0]            o_ocw_stb;
  logic [PIC_DATA_W-1:0] o_data_out;
  logic                  o_init_done;
  logic                  o_sngl;
  logic                  o_ic4;
  logic                  o_seq_err;
`ifdef PIC_READBACK_EN
  logic [PIC_DATA_W-1:0] i_irr_in;
  logic [PIC_DATA_W-1:0] i_isr_in;
  logic [PIC_DATA_W-1:0] i_imr_in;
  logic [PIC_DATA_W-1:0] o_dout;
  logic                  o_dout_oe;
`endif

  modport slave (
    input  i_cs_n, i_wr_n, i_rd_n, i_a0, i_din,
`ifdef PIC_READBACK_EN
    input  i_irr_in, i_isr_in, i_imr_in,
    output o_dout, o_dout_oe,
`endif
    output o_icw_stb, o_ocw_stb, o_data_out, o_init_done, o_sngl, o_ic4, o_seq_err
  );

  modport master (
    output i_cs_n, i_wr_n, i_rd_n, i_a0, i_din,
`ifdef PIC_READBACK_EN
    output i_irr_in, i_isr_in, i_imr_in,
    input  o_dout, o_dout_oe,
`endif
    input  o_icw_stb, o_ocw_stb, o_data_out, o_init_done, o_sngl, o_ic4, o_seq_err
  );

endinterface

// File: rtl/pic_bus_sync.sv
// Synchroniser chains and rising-edge detect for the asynchronous wr_n/rd_n/cs_n.
module pic_bus_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_wr_n,
  input  logic i_rd_n,
  input  logic i_cs_n,
  output logic o_wr_n_s,
  output logic o_rd_n_s,
  output logic o_cs_n_s,
  output logic o_wr_rise,
  output logic o_rd_rise,
  output logic o_cs_rise
);

  // Bit order {cs, rd, wr}. wr resets low so the idle-high line after reset
  // looks like a rise that the top rejects until it has seen wr high itself.
  localparam logic [2:0] RST_VAL = 3'b110;

  logic [2:0] r_sync [SYNC_STAGES];
  logic [2:0] r_prev;
  logic [2:0] w_lvl;
  logic [2:0] w_rise;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++)
        r_sync[i] <= RST_VAL;
      r_prev <= RST_VAL;
    end else begin
      r_sync[0] <= {i_cs_n, i_rd_n, i_wr_n};
      for (int i = 1; i < SYNC_STAGES; i++)
        r_sync[i] <= r_sync[i-1];
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign w_lvl  = r_sync[SYNC_STAGES-1];
  assign w_rise = w_lvl & ~r_prev;

  assign o_wr_n_s  = w_lvl[0];
  assign o_rd_n_s  = w_lvl[1];
  assign o_cs_n_s  = w_lvl[2];
  assign o_wr_rise = w_rise[0];
  assign o_rd_rise = w_rise[1];
  assign o_cs_rise = w_rise[2];

endmodule

// File: rtl/pic_rw_sequencer.sv
// 8259 bus-interface stage: captures CPU writes, tracks the ICW sequence and
// emits one-cycle ICW/OCW strobes. Define PIC_READBACK_EN for IRR/ISR/IMR readback.
module pic_rw_sequencer
  import pic_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DATA_W      = PIC_DATA_W
) (
  input logic               clk,
  input logic               rst,
  pic_rw_sequencer_if.slave bus
);

  logic w_wr_n_s;
  logic w_rd_n_s;
  logic w_cs_n_s;
  logic w_wr_rise;
  logic w_rd_rise;
  logic w_cs_rise;

  pic_bus_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk       (clk),
    .rst       (rst),
    .i_wr_n    (bus.i_wr_n),
    .i_rd_n    (bus.i_rd_n),
    .i_cs_n    (bus.i_cs_n),
    .o_wr_n_s  (w_wr_n_s),
    .o_rd_n_s  (w_rd_n_s),
    .o_cs_n_s  (w_cs_n_s),
    .o_wr_rise (w_wr_rise),
    .o_rd_rise (w_rd_rise),
    .o_cs_rise (w_cs_rise)
  );

  logic              r_cap_cs;
  logic              r_cap_a0;
  logic [DATA_W-1:0] r_cap_din;
  logic              r_armed;

  // Capture runs while the synced strobe is low; r_armed blocks a write that
  // was already in progress when reset released.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cap_cs  <= 1'b0;
      r_cap_a0  <= 1'b0;
      r_cap_din <= '0;
      r_armed   <= 1'b0;
    end else begin
      if (w_wr_n_s)
        r_armed <= 1'b1;
      if (!w_wr_n_s) begin
        r_cap_cs <= ~w_cs_n_s;
        if (!w_cs_n_s) begin
          r_cap_a0  <= bus.i_a0;
          r_cap_din <= bus.i_din;
        end
      end
    end
  end

  logic w_commit;
  logic w_is_icw1;
  logic w_valid;
  logic [3:0] w_icw;
  logic [2:0] w_ocw;
  state_t w_next;
  state_t r_state;

  logic              r_sngl;
  logic              r_ic4;
  logic [3:0]        r_icw_stb;
  logic [2:0]        r_ocw_stb;
  logic [DATA_W-1:0] r_data_out;
  logic              r_init_done;
  logic              r_seq_err;

  assign w_commit  = w_wr_rise & r_cap_cs & r_armed;
  assign w_is_icw1 = ~r_cap_a0 & r_cap_din[D4_B];
  assign w_valid   = |{w_icw, w_ocw};

  always_comb begin
    w_icw  = '0;
    w_ocw  = '0;
    w_next = r_state;
    if (w_is_icw1) begin
      w_icw[ICW1_B] = 1'b1;
      w_next        = WAIT_ICW2;
    end else begin
      case (r_state)
        WAIT_ICW2: if (r_cap_a0) begin
          w_icw[ICW2_B] = 1'b1;
          w_next        = next_after_icw2(r_sngl, r_ic4);
        end
        WAIT_ICW3: if (r_cap_a0) begin
          w_icw[ICW3_B] = 1'b1;
          w_next        = next_after_icw3(r_ic4);
        end
        WAIT_ICW4: if (r_cap_a0) begin
          w_icw[ICW4_B] = 1'b1;
          w_next        = READY;
        end
        READY: begin
          if (r_cap_a0)
            w_ocw[OCW1_B] = 1'b1;
          else if (r_cap_din[D3_B])
            w_ocw[OCW3_B] = 1'b1;
          else
            w_ocw[OCW2_B] = 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef PIC_READBACK_EN
  logic r_ris;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= UNINIT;
      r_icw_stb   <= '0;
      r_ocw_stb   <= '0;
      r_data_out  <= '0;
      r_init_done <= 1'b0;
      r_sngl      <= 1'b0;
      r_ic4       <= 1'b0;
      r_seq_err   <= 1'b0;
`ifdef PIC_READBACK_EN
      r_ris       <= 1'b0;
`endif
    end else begin
      r_icw_stb <= '0;
      r_ocw_stb <= '0;
      r_seq_err <= 1'b0;
      if (w_commit) begin
        if (w_valid) begin
          r_icw_stb  <= w_icw;
          r_ocw_stb  <= w_ocw;
          r_data_out <= r_cap_din;
          r_state    <= w_next;
          if (|w_icw)
            r_init_done <= (w_next == READY);
          if (w_is_icw1) begin
            r_sngl <= r_cap_din[D1_B];
            r_ic4  <= r_cap_din[D0_B];
          end
`ifdef PIC_READBACK_EN
          if (w_ocw[OCW3_B] && r_cap_din[D1_B])
            r_ris <= r_cap_din[D0_B];
`endif
        end else begin
          r_seq_err <= 1'b1;
        end
      end
    end
  end

  assign bus.o_icw_stb   = r_icw_stb;
  assign bus.o_ocw_stb   = r_ocw_stb;
  assign bus.o_data_out  = r_data_out;
  assign bus.o_init_done = r_init_done;
  assign bus.o_sngl      = r_sngl;
  assign bus.o_ic4       = r_ic4;
  assign bus.o_seq_err   = r_seq_err;

`ifdef PIC_READBACK_EN
  logic [DATA_W-1:0] r_dout;
  logic              r_dout_oe;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dout    <= '0;
      r_dout_oe <= 1'b0;
    end else if (!w_rd_n_s && !w_cs_n_s) begin
      r_dout_oe <= 1'b1;
      r_dout    <= bus.i_a0 ? bus.i_imr_in : (r_ris ? bus.i_isr_in : bus.i_irr_in);
    end else begin
      r_dout_oe <= 1'b0;
      r_dout    <= '0;
    end
  end

  assign bus.o_dout    = r_dout;
  assign bus.o_dout_oe = r_dout_oe;

  logic w_unused_edges;
  assign w_unused_edges = &{1'b0, w_rd_rise, w_cs_rise};
`else
  logic w_unused_edges;
  assign w_unused_edges = &{1'b0, w_rd_rise, w_cs_rise, w_rd_n_s};
`endif

endmodule

// File: tb/tb_pic_rw_sequencer.sv
// Randomised + directed bench for pic_rw_sequencer against a queue-based write model.
// Readback section is active only when PIC_READBACK_EN is defined.
module tb_pic_rw_sequencer;

  localparam int SYNC = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  pic_rw_sequencer_if bus();

  pic_rw_sequencer #(
    .SYNC_STAGES(SYNC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct packed {
    logic [3:0] icw;
    logic [2:0] ocw;
    logic       err;
    logic [7:0] data;
    logic       init;
    logic       sngl;
    logic       ic4;
  } obs_t;

  int nChecks = 0;
  int nPass   = 0;
  int errSeen = 0;

  obs_t       expQ[$];
  int         pushCyc[$];
  logic [6:0] stbLog[$];

  // Model: mNext is the ICW number expected next (0 = uninitialised, 5 = ready)
  int         mNext;
  logic [7:0] mData;
  logic       mInit, mSngl, mIc4, mRis;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act === exp)
      nPass++;
    else
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic void modelReset();
    mNext = 0;
    mData = 8'h00;
    mInit = 1'b0;
    mSngl = 1'b0;
    mIc4  = 1'b0;
    mRis  = 1'b0;
    expQ.delete();
    pushCyc.delete();
  endfunction

  function automatic obs_t modelWrite(input logic a0, input logic [7:0] d);
    obs_t e;
    e = '0;
    if (!a0 && d[4]) begin
      e.icw = 4'b0001;
      mSngl = d[1];
      mIc4  = d[0];
      mInit = 1'b0;
      mNext = 2;
    end else if (mNext >= 2 && mNext <= 4 && a0) begin
      e.icw = 4'b0001 << (mNext - 1);
      if (mNext == 2)
        mNext = !mSngl ? 3 : (mIc4 ? 4 : 5);
      else if (mNext == 3)
        mNext = mIc4 ? 4 : 5;
      else
        mNext = 5;
      mInit = (mNext == 5);
    end else if (mNext == 5) begin
      if (a0)
        e.ocw = 3'b001;
      else if (d[3]) begin
        e.ocw = 3'b100;
        if (d[1]) mRis = d[0];
      end else
        e.ocw = 3'b010;
    end else begin
      e.err = 1'b1;
    end
    if (!e.err) mData = d;
    e.data = mData;
    e.init = mInit;
    e.sngl = mSngl;
    e.ic4  = mIc4;
    return e;
  endfunction

  // Compare process: every DUT event must match the oldest expected write;
  // between events the held outputs must match the model
  always @(negedge clk) begin
    obs_t act;
    if (!rst) begin
      act.icw  = bus.o_icw_stb;
      act.ocw  = bus.o_ocw_stb;
      act.err  = bus.o_seq_err;
      act.data = bus.o_data_out;
      act.init = bus.o_init_done;
      act.sngl = bus.o_sngl;
      act.ic4  = bus.o_ic4;
      if (|{act.icw, act.ocw, act.err}) begin
        checkOutput("onehot", $countones({act.icw, act.ocw, act.err}), 1);
        stbLog.push_back({act.icw, act.ocw});
        if (act.err) errSeen++;
        if (expQ.size() == 0)
          checkOutput("unexpected_event", act, 0);
        else begin
          checkOutput("event", act, expQ.pop_front());
          checkOutput("latency", cyc - pushCyc.pop_front(), SYNC + 1);
        end
      end else if (expQ.size() == 0) begin
        checkOutput("idle", {act.data, act.init, act.sngl, act.ic4},
                    {mData, mInit, mSngl, mIc4});
      end
    end
  end

  task automatic applyStimulus(input logic a0v, input logic [7:0] d, input logic csHigh);
    int hold, gap;
    hold = $urandom_range(4, 2);
    gap  = $urandom_range(4, 1);
    @(posedge clk); #1;
    bus.i_cs_n = csHigh;
    bus.i_a0   = a0v;
    bus.i_din  = d;
    bus.i_wr_n = 1'b0;
    repeat (hold) @(posedge clk);
    #1;
    bus.i_wr_n = 1'b1;
    if (!csHigh) begin
      expQ.push_back(modelWrite(a0v, d));
      pushCyc.push_back(cyc);
    end
    @(posedge clk); #1;
    bus.i_cs_n = 1'b1;
    repeat (gap) @(posedge clk);
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while (expQ.size() != 0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    @(negedge clk);
    checkOutput("drain", expQ.size(), 0);
    expQ.delete();
    pushCyc.delete();
  endtask

  task automatic doReset();
    @(posedge clk); #1;
    rst = 1'b1;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_icw"},  bus.o_icw_stb, 0);
    checkOutput({tag, "_ocw"},  bus.o_ocw_stb, 0);
    checkOutput({tag, "_data"}, bus.o_data_out, 0);
    checkOutput({tag, "_flags"}, {bus.o_init_done, bus.o_sngl, bus.o_ic4, bus.o_seq_err}, 0);
`ifdef PIC_READBACK_EN
    checkOutput({tag, "_dout"}, {bus.o_dout_oe, bus.o_dout}, 0);
`endif
  endtask

`ifdef PIC_READBACK_EN
  task automatic doRead(input logic a0v, input logic [7:0] expLit);
    @(posedge clk); #1;
    bus.i_a0   = a0v;
    bus.i_cs_n = 1'b0;
    bus.i_rd_n = 1'b0;
    repeat (SYNC + 2) @(posedge clk);
    @(negedge clk);
    checkOutput("rd_oe", bus.o_dout_oe, 1);
    checkOutput("rd_model", bus.o_dout,
                a0v ? bus.i_imr_in : (mRis ? bus.i_isr_in : bus.i_irr_in));
    checkOutput("rd_literal", bus.o_dout, expLit);
    #1;
    bus.i_rd_n = 1'b1;
    bus.i_cs_n = 1'b1;
    repeat (SYNC + 2) @(posedge clk);
    @(negedge clk);
    checkOutput("rd_oe_off", bus.o_dout_oe, 0);
  endtask
`endif

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $display("%0d/%0d checks passed", nPass, nChecks);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.i_cs_n = 1'b1;
    bus.i_wr_n = 1'b1;
    bus.i_rd_n = 1'b1;
    bus.i_a0   = 1'b0;
    bus.i_din  = 8'h00;
`ifdef PIC_READBACK_EN
    bus.i_irr_in = 8'h11;
    bus.i_isr_in = 8'h80;
    bus.i_imr_in = 8'hFB;
`endif
    modelReset();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    checkResetOutputs("reset");

    // Single mode, no ICW4
    stbLog.delete();
    applyStimulus(1'b0, 8'h12, 1'b0); waitDrain();
    checkOutput("t1_init_mid", bus.o_init_done, 0);
    applyStimulus(1'b1, 8'h40, 1'b0); waitDrain();
    checkOutput("t1_log", {stbLog[0], stbLog[1]}, {7'b0001000, 7'b0010000});
    checkOutput("t1_done", {bus.o_init_done, bus.o_data_out}, {1'b1, 8'h40});

    // Cascade with ICW4
    stbLog.delete();
    applyStimulus(1'b0, 8'h11, 1'b0); waitDrain();
    checkOutput("t2_d1", bus.o_data_out, 8'h11);
    applyStimulus(1'b1, 8'h20, 1'b0); waitDrain();
    checkOutput("t2_d2", bus.o_data_out, 8'h20);
    applyStimulus(1'b1, 8'h04, 1'b0); waitDrain();
    checkOutput("t2_d3", {bus.o_init_done, bus.o_data_out}, {1'b0, 8'h04});
    applyStimulus(1'b1, 8'h03, 1'b0); waitDrain();
    checkOutput("t2_d4", {bus.o_init_done, bus.o_data_out}, {1'b1, 8'h03});
    checkOutput("t2_log", {stbLog[0], stbLog[1], stbLog[2], stbLog[3]},
                {7'b0001000, 7'b0010000, 7'b0100000, 7'b1000000});

    // OCWs in READY
    stbLog.delete();
    applyStimulus(1'b1, 8'hFB, 1'b0); waitDrain();
    applyStimulus(1'b0, 8'h20, 1'b0); waitDrain();
    applyStimulus(1'b0, 8'h0B, 1'b0); waitDrain();
    checkOutput("t3_log", {stbLog[0], stbLog[1], stbLog[2]},
                {7'b0000001, 7'b0000010, 7'b0000100});
    checkOutput("t3_data", bus.o_data_out, 8'h0B);

`ifdef PIC_READBACK_EN
    doRead(1'b0, 8'h80);
    doRead(1'b1, 8'hFB);
`endif

    // ICW1 restart from WAIT_ICW3
    stbLog.delete();
    applyStimulus(1'b0, 8'h11, 1'b0); waitDrain();
    applyStimulus(1'b1, 8'h20, 1'b0); waitDrain();
    applyStimulus(1'b0, 8'h13, 1'b0); waitDrain();
    checkOutput("t4_restart", {bus.o_sngl, bus.o_init_done, stbLog[2]}, {1'b1, 1'b0, 7'b0001000});
    applyStimulus(1'b1, 8'h55, 1'b0); waitDrain();
    checkOutput("t4_icw2", stbLog[3], 7'b0010000);

    // UNINIT error, cs-high write, reset mid-write
    doReset();
    errSeen = 0;
    stbLog.delete();
    applyStimulus(1'b1, 8'hFF, 1'b0); waitDrain();
    checkOutput("t5_err", {errSeen[7:0], stbLog[0]}, {8'd1, 7'b0000000});
    applyStimulus(1'b1, 8'hAA, 1'b1); waitDrain();
    checkOutput("t5_cs_high", errSeen, 1);

    @(posedge clk); #1;
    bus.i_cs_n = 1'b0;
    bus.i_a0   = 1'b0;
    bus.i_din  = 8'h13;
    bus.i_wr_n = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    bus.i_wr_n = 1'b1;
    @(posedge clk); #1;
    bus.i_cs_n = 1'b1;
    repeat (8) @(posedge clk);
    @(negedge clk);
    checkResetOutputs("t5_rst");
    applyStimulus(1'b0, 8'h12, 1'b0); waitDrain();
    checkOutput("t5_after", bus.o_data_out, 8'h12);

    // Randomised write streams, back-to-back without draining
    doReset();
    for (int i = 0; i < 120; i++) begin
      int kind;
      logic [7:0] d;
      kind = $urandom_range(99, 0);
      d    = 8'($urandom);
      if (kind < 20)
        applyStimulus(1'b0, d | 8'h10, 1'b0);
      else if (kind < 65)
        applyStimulus(1'b1, d, 1'b0);
      else if (kind < 92)
        applyStimulus(1'b0, d & 8'hEF, 1'b0);
      else
        applyStimulus(logic'($urandom_range(1, 0)), d, 1'b1);
      if (i % 15 == 14) waitDrain();
    end
    waitDrain();

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule

// File: doc/pic_rw_sequencer.md
Name: pic_rw_sequencer

Overview:
- Upstream bus-interface stage of the 8259 PIC; sits directly in front of the control logic.
- Samples CPU-side CS_n/WR_n/RD_n/A0/D[7:0] and tracks the ICW1→ICW2→(ICW3)→(ICW4) initialisation sequence.
- Classifies each completed write and emits one-cycle one-hot ICW/OCW strobes with the captured data byte.
- Control logic consumes these strobes as its ICWs[4:1], OCWs and datain inputs.

Parameters:
- SYNC_STAGES, 2, flops used to synchronise wr_n/rd_n/cs_n into clk (minimum 2).
- DATA_W, 8, data bus width; fixed at 8 for 8259 compatibility.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- cs_n  in  1  chip select, active low, asynchronous.
- wr_n  in  1  write strobe, active low, asynchronous.
- rd_n  in  1  read strobe, active low, asynchronous.
- a0  in  1  address bit 0.
- din  in  8  CPU write data.
- icw_stb  out  4  one-hot ICW1..ICW4 strobe; bit0 = ICW1.
- ocw_stb  out  3  one-hot OCW1..OCW3 strobe; bit0 = OCW1.
- data_out  out  8  byte captured by the last committed write; held stable.
- init_done  out  1  high once the ICW sequence is complete.
- sngl  out  1  ICW1 D1, latched.
- ic4  out  1  ICW1 D0, latched.
- seq_err  out  1  one-cycle pulse when a write is discarded.
- irr_in, isr_in, imr_in  in  8 each  register values for readback (READBACK_EN only).
- dout  out  8  read data (READBACK_EN only).
- dout_oe  out  1  read-drive enable (READBACK_EN only).

Behaviour:
- Reset (synchronous, active-high):
  - state=UNINIT.
  - All strobes 0; data_out=0; init_done=0; sngl=0; ic4=0; seq_err=0; dout=0; dout_oe=0.
  - Read select = IRR.
- Write capture:
  - wr_n and cs_n pass through SYNC_STAGES flops.
  - While synced wr_n=0 and cs_n=0, a0/din are registered each cycle.
  - A write commits on the cycle where synced wr_n goes 0→1 and the captured cs was low.
  - Strobe asserts in the cycle after the commit, for exactly one cycle.
  - data_out updates in the same cycle as the strobe.
- Decode priority:
  - a0=0 and D4=1 → ICW1, from any state; restarts the sequence, clears init_done, latches sngl/ic4.
  - Else, by state:
    - WAIT_ICW2: a0=1 → ICW2.
    - WAIT_ICW3: a0=1 → ICW3.
    - WAIT_ICW4: a0=1 → ICW4.
    - READY: a0=1 → OCW1; a0=0, D4=0, D3=0 → OCW2; a0=0, D4=0, D3=1 → OCW3.
  - Any other write → no strobe, seq_err pulse, state unchanged.
  - Any write in UNINIT other than ICW1 counts as "any other write".
- State transitions:
  - UNINIT→WAIT_ICW2 on ICW1.
  - WAIT_ICW2→WAIT_ICW3 if sngl=0.
  - WAIT_ICW2→WAIT_ICW4 if sngl=1 and ic4=1.
  - WAIT_ICW2→READY if sngl=1 and ic4=0.
  - WAIT_ICW3→WAIT_ICW4 if ic4=1, else →READY.
  - WAIT_ICW4→READY.
  - init_done=1 from the strobe cycle of the final ICW.
- Read: rd_n ignored for state; reads never change the sequence.
- Boundary conditions:
  - wr_n rising with cs_n high: ignored, no seq_err.
  - rst asserted mid-write: the write is lost; after rst, writes are accepted only once synced wr_n has been seen high.
  - Back-to-back writes ≥ SYNC_STAGES+2 clk apart are each committed.
  - At most one strobe bit active per cycle across icw_stb|ocw_stb.

Optional Feature:
- Macro: PIC_READBACK_EN.
- With the macro:
  - OCW3 with D1=1 latches RIS=D0 (0 selects IRR, 1 selects ISR).
  - While synced rd_n=0 and cs_n=0:
    - dout_oe=1.
    - dout=imr_in if a0=1, else ISR/IRR per RIS.
  - dout is registered with 1 cycle latency.
- Without the macro: readback ports absent; OCW3 is still strobed, with no local effect.

Decomposition:
- Package pic_pkg holds:
  - state enum (UNINIT, WAIT_ICW2, WAIT_ICW3, WAIT_ICW4, READY);
  - strobe bit index constants ICW1_B..ICW4_B, OCW1_B..OCW3_B;
  - D4/D3/D1/D0 bit-position constants.
- One sub-module, pic_bus_sync: synchroniser chain plus rising-edge detect for wr_n, rd_n and cs_n.

Test Plan:
1. Single mode, no ICW4: ICW1=0x12, ICW2=0x40 → icw_stb 0001 then 0010, each one cycle; init_done=1 after ICW2; state READY.
2. Cascade with ICW4: ICW1=0x11, ICW2=0x20, ICW3=0x04, ICW4=0x03 → strobes 0001, 0010, 0100, 1000; data_out 0x11, 0x20, 0x04, 0x03; init_done only after 0x03.
3. READY: OCW1 a0=1 0xFB; OCW2 a0=0 0x20; OCW3 a0=0 0x0B → ocw_stb 001, 010, 100 with matching data_out.
4. In WAIT_ICW3, write a0=0 0x13 → treated as ICW1 restart; icw_stb=0001; sngl=1; next a0=1 write → ICW2.
5. In UNINIT, write a0=1 0xFF → no strobe, seq_err one-cycle pulse; rst pulsed mid-write (wr_n low) → no strobe, all outputs at reset values.
6. PIC_READBACK_EN: OCW3 0x0B, then rd a0=0 with isr_in=0x80 → dout=0x80, dout_oe=1; rd a0=1 with imr_in=0xFB → dout=0xFB.
